shift_register: RTL and testbench



---
 rtl/shift_register.sv | 88 ++++++++
 tb/tb_shift_register.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//
// Parameterised serial-in / parallel-out shift register with a serial output,
// a shift enable, a shift direction and a synchronous parallel load. It serves
// as a generic serialiser/deserialiser stage in datapath blocks.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset; clears q (and match)
//   in         serial data input
//   en         shift enable: 1 = shift this cycle, 0 = hold
//   dir        0: in enters q[0] and moves toward q[WIDTH-1]
//              1: in enters q[WIDTH-1] and moves toward q[0]
//   load       synchronous parallel load strobe (beats en)
//   load_data  parallel load value, indexed [0:WIDTH-1]
//   q          register contents, indexed [0:WIDTH-1]
//   sout       bit about to be shifted out: q[WIDTH-1] for dir=0, q[0] for dir=1
//
// Optional feature, macro SHIFT_REGISTER_MATCH_EN:
//   pattern    compare value, indexed [0:WIDTH-1]
//   match      registered; high in the same cycle that q shows pattern
//
// Edge priority: rst_n low, then load, then en, then hold.
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module shift_register #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [0:WIDTH-1] load_data,
`ifdef SHIFT_REGISTER_MATCH_EN
   input  logic [0:WIDTH-1] pattern,
   output logic             match,
`endif
   output logic [0:WIDTH-1] q,
   output logic             sout
);

   logic [0:WIDTH-1] r_q;
   logic [0:WIDTH-1] w_q_next;

   // Value q takes on the next edge when reset is not asserted. The optional
   // match flag compares against this so it lines up with q itself.
   always_comb begin
      w_q_next = r_q;
      if (load) begin
         w_q_next = load_data;
      end else if (en) begin
         if (!dir) begin
            w_q_next = {in, r_q[0:WIDTH-2]};
         end else begin
            w_q_next = {r_q[1:WIDTH-1], in};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_next;
      end
   end

   assign q    = r_q;
   assign sout = dir ? r_q[0] : r_q[WIDTH-1];

`ifdef SHIFT_REGISTER_MATCH_EN
   logic r_match;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_match <= 1'b0;
      end else begin
         r_match <= (w_q_next == pattern);
      end
   end

   assign match = r_match;
`endif

endmodule

// File: tb/tb_shift_register.sv
module tb_shift_register;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             s_in;
   logic             en;
   logic             dir;
   logic             load;
   logic [0:WIDTH-1] load_data;
   logic [0:WIDTH-1] q;
   logic             sout;
`ifdef SHIFT_REGISTER_MATCH_EN
   logic [0:WIDTH-1] pattern;
   logic             match;
`endif

   int n_checks = 0;
   int n_errors = 0;

   shift_register #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (s_in),
      .en        (en),
      .dir       (dir),
      .load      (load),
      .load_data (load_data),
`ifdef SHIFT_REGISTER_MATCH_EN
      .pattern   (pattern),
      .match     (match),
`endif
      .q         (q),
      .sout      (sout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the register as a queue of bits, element 0 = q[0].
   bit               mq[$];
   bit               m_valid = 1'b0;
   bit               m_match = 1'b0;
   logic [0:WIDTH-1] m_vec;

   function automatic logic [0:WIDTH-1] model_vec();
      logic [0:WIDTH-1] v;
      for (int i = 0; i < WIDTH; i++) v[i] = mq[i];
      return v;
   endfunction

   initial begin
      for (int i = 0; i < WIDTH; i++) mq.push_back(1'b0);
   end

   // Model update on each edge, then one compare a few ns later.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) mq[i] = 1'b0;
         m_valid = 1'b1;
         m_match = 1'b0;
      end else begin
         if (load) begin
            for (int i = 0; i < WIDTH; i++) mq[i] = load_data[i];
            m_valid = 1'b1;
         end else if (en) begin
            if (!dir) begin
               mq.push_front(s_in);
               void'(mq.pop_back());
            end else begin
               mq.push_back(s_in);
               void'(mq.pop_front());
            end
         end
`ifdef SHIFT_REGISTER_MATCH_EN
         m_match = (model_vec() == pattern);
`endif
      end
      #3;
      if (m_valid) begin
         m_vec = model_vec();
         chk("model_q", 32'(q), 32'(m_vec));
         chk("model_sout", 32'(sout), 32'(dir ? mq[0] : mq[WIDTH-1]));
`ifdef SHIFT_REGISTER_MATCH_EN
         chk("model_match", 32'(match), 32'(m_match));
`endif
      end
   end

   // Inputs change 4 ns after the edge, well away from the next one.
   task automatic tick();
      @(posedge clk);
      #4;
   endtask

   initial begin
      rst_n = 1'b1; s_in = 1'b0; en = 1'b0; dir = 1'b0;
      load = 1'b1; load_data = 4'b1111;
`ifdef SHIFT_REGISTER_MATCH_EN
      pattern = 4'b0110;
`endif
      #2;
      tick();
      chk("preload_q", 32'(q), 32'(4'b1111));

      // Reset clears a full register.
      rst_n = 1'b0; load = 1'b0;
      tick();
      chk("reset_q", 32'(q), 32'(4'b0000));
      chk("reset_sout", 32'(sout), 32'd0);

      // Reset beats load and en on the same edge.
      load = 1'b1; load_data = 4'b1111; en = 1'b1; s_in = 1'b1;
      tick();
      chk("reset_prio_q", 32'(q), 32'(4'b0000));

      // Shift toward q[WIDTH-1]: stream 1,0,1,1.
      rst_n = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b0;
      s_in = 1'b1; tick(); chk("shr_1", 32'(q), 32'(4'b1000));
      s_in = 1'b0; tick(); chk("shr_2", 32'(q), 32'(4'b0100));
      s_in = 1'b1; tick(); chk("shr_3", 32'(q), 32'(4'b1010));
      s_in = 1'b1; tick(); chk("shr_4", 32'(q), 32'(4'b1101));
      chk("shr_sout", 32'(sout), 32'd1);

      // Shift toward q[0].
      load = 1'b1; load_data = 4'b0000; tick();
      load = 1'b0; en = 1'b1; dir = 1'b1;
      s_in = 1'b1; tick(); chk("shl_1", 32'(q), 32'(4'b0001));
      s_in = 1'b0; tick(); chk("shl_2", 32'(q), 32'(4'b0010));
      chk("shl_sout", 32'(sout), 32'd0);
      dir = 1'b0; #1;
      chk("dir_sout", 32'(sout), 32'd0);
      load = 1'b1; load_data = 4'b1000; en = 1'b0; tick();
      dir = 1'b1; #1; chk("dir_sout_q0", 32'(sout), 32'd1);
      dir = 1'b0; #1; chk("dir_sout_q3", 32'(sout), 32'd0);

      // Load beats en, then hold.
      load_data = 4'b1001; load = 1'b1; en = 1'b1; s_in = 1'b0;
      tick(); chk("load_prio", 32'(q), 32'(4'b1001));
      load = 1'b0; en = 1'b0; s_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("hold", 32'(q), 32'(4'b1001));
      end

      // 32 random bits shifting toward q[WIDTH-1].
      en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 32; i++) begin
         s_in = 1'($urandom_range(0, 1));
         tick();
      end

`ifdef SHIFT_REGISTER_MATCH_EN
      // Pattern 0110 arrives on the fourth edge of stream 0,1,1,0.
      pattern = 4'b0110;
      rst_n = 1'b0; tick();
      rst_n = 1'b1; en = 1'b1; dir = 1'b0;
      s_in = 1'b0; tick(); chk("match_a", 32'(match), 32'd0);
      s_in = 1'b1; tick(); chk("match_b", 32'(match), 32'd0);
      s_in = 1'b1; tick(); chk("match_c", 32'(match), 32'd0);
      s_in = 1'b0; tick(); chk("match_hit", 32'(match), 32'd1);
      chk("match_q", 32'(q), 32'(4'b0110));
      s_in = 1'b0; tick(); chk("match_after", 32'(match), 32'd0);
      // Reset on the edge that would produce the pattern.
      load = 1'b1; load_data = 4'b1100; tick();
      load = 1'b0; s_in = 1'b0; rst_n = 1'b0;
      tick(); chk("match_reset", 32'(match), 32'd0);
      rst_n = 1'b1;
`endif

      // Fully random traffic, including resets, loads and direction flips.
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 19) != 0);
         load      = ($urandom_range(0, 7) == 0);
         en        = ($urandom_range(0, 3) != 0);
         dir       = 1'($urandom_range(0, 1));
         s_in      = 1'($urandom_range(0, 1));
         load_data = 4'($urandom_range(0, 15));
`ifdef SHIFT_REGISTER_MATCH_EN
         if ($urandom_range(0, 15) == 0) pattern = 4'($urandom_range(0, 15));
`endif
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
